// File: rtl/fp_cvt_arbiter.sv
// Round-robin arbiter sharing one fixed-latency float-to-int32 converter among NREQ requesters.
// Define FP_CVT_ARB_STATS_EN to add the stat_issued / stat_sat counters.
module fp_cvt_arbiter #(
  parameter int NREQ       = 4,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          cvt_a,
  input  logic [31:0]          cvt_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
`ifdef FP_CVT_ARB_STATS_EN
  output logic [31:0]          stat_issued,
  output logic [31:0]          stat_sat,
`endif
  output logic                 busy
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [IDW-1:0]                 rr_q, rr_d;
  logic [LAT-1:0]                 vld_pipe_q, vld_pipe_d;
  logic [LAT-1:0][IDW-1:0]        id_pipe_q, id_pipe_d;
  logic [FIFO_DEPTH-1:0][31:0]    dat_mem_q, dat_mem_d;
  logic [FIFO_DEPTH-1:0][IDW-1:0] id_mem_q, id_mem_d;
  logic [AW-1:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                    cnt_q, cnt_d;

  logic           found, can_issue, grant, push, pop;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   arb_idx;
  int             inflight;

  // Credit counts only registered state, so a same-cycle pop frees a slot one cycle later.
  always_comb begin
    inflight = 0;
    for (int s = 0; s < LAT; s++) inflight = inflight + int'(vld_pipe_q[s]);
    can_issue = (int'(cnt_q) + inflight) < FIFO_DEPTH;
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    arb_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = {1'b0, rr_q} + (IDW+1)'(k);
      if (arb_idx >= (IDW+1)'(NREQ)) arb_idx = arb_idx - (IDW+1)'(NREQ);
      if (!found && req_valid[arb_idx[IDW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = arb_idx[IDW-1:0];
      end
    end
    grant     = found & can_issue & ~rst;
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
    cvt_a = grant ? req_data[32*int'(gnt_idx) +: 32] : 32'h0;
    rr_d  = rr_q;
    if (grant) rr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
  end

  always_comb begin
    vld_pipe_d    = '0;
    id_pipe_d     = '0;
    vld_pipe_d[0] = grant;
    id_pipe_d[0]  = grant ? gnt_idx : '0;
    for (int s = 1; s < LAT; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      id_pipe_d[s]  = id_pipe_q[s-1];
    end
  end

  assign push      = vld_pipe_q[LAT-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = rsp_valid ? dat_mem_q[rd_ptr_q] : 32'h0;
  assign rsp_id    = rsp_valid ? id_mem_q[rd_ptr_q] : '0;
  assign busy      = (|vld_pipe_q) | rsp_valid;

  always_comb begin
    dat_mem_d = dat_mem_q;
    id_mem_d  = id_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) begin
      dat_mem_d[wr_ptr_q] = cvt_z;
      id_mem_d[wr_ptr_q]  = id_pipe_q[LAT-1];
      wr_ptr_d            = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

`ifdef FP_CVT_ARB_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d, stat_sat_q, stat_sat_d;
  always_comb begin
    stat_issued_d = stat_issued_q + 32'(grant);
    stat_sat_d    = stat_sat_q + 32'(push && (cvt_z == 32'h8000_0000));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_sat_q    <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_sat_q    <= stat_sat_d;
    end
  end
  assign stat_issued = stat_issued_q;
  assign stat_sat    = stat_sat_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      dat_mem_q  <= '0;
      id_mem_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
      dat_mem_q  <= dat_mem_d;
      id_mem_q   <= id_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule
